// File: rtl/scalar_fust.sv
// scalar_fust: scalar functional-unit status table (scoreboard).
// Accepts one decoded instruction per cycle into the row of its target FU,
// tracks RAW/WAW dependences through a per-register result-status table,
// issues the lowest-indexed operand-ready row, and frees rows on writeback.
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   dis_valid/fu/rd/rs1/rs2        dispatch request
//   dis_ready, hazard              dispatch accept / stall (combinational)
//   iss_valid/fu/rd/rs1/rs2        selected issuable row (combinational)
//   iss_ready                      FU accepts the issue
//   wb_valid, wb_fu                FU completion
//   fu_busy                        per-row busy flags
module scalar_fust #(
   parameter int unsigned NUM_FU = 3,
   parameter int unsigned FU_S_W = 2,
   parameter int unsigned REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dis_valid,
   input  logic [FU_S_W-1:0] dis_fu,
   input  logic [REG_W-1:0]  dis_rd,
   input  logic [REG_W-1:0]  dis_rs1,
   input  logic [REG_W-1:0]  dis_rs2,
   output logic              dis_ready,
   output logic              hazard,
   output logic              iss_valid,
   output logic [FU_S_W-1:0] iss_fu,
   output logic [REG_W-1:0]  iss_rd,
   output logic [REG_W-1:0]  iss_rs1,
   output logic [REG_W-1:0]  iss_rs2,
   input  logic              iss_ready,
   input  logic              wb_valid,
   input  logic [FU_S_W-1:0] wb_fu,
   output logic [NUM_FU-1:0] fu_busy
);

   localparam int unsigned NUM_REG = 1 << REG_W;

   typedef enum logic [1:0] {FREE = 2'd0, WAIT = 2'd1, ISSUED = 2'd2} row_state_e;

   typedef struct packed {
      row_state_e          state;
      logic [REG_W-1:0]    r;
      logic [REG_W-1:0]    r1;
      logic [REG_W-1:0]    r2;
      logic [FU_S_W-1:0]   t1;
      logic [FU_S_W-1:0]   t2;
      logic                p1;
      logic                p2;
   } row_t;

   row_t               row_q [NUM_FU];
   row_t               row_d [NUM_FU];
   logic [NUM_REG-1:0] rs_valid_q, rs_valid_d;
   logic [FU_S_W-1:0]  rs_fu_q [NUM_REG];
   logic [FU_S_W-1:0]  rs_fu_d [NUM_REG];

   logic               wb_hit_c;
   logic               dis_fu_ok_c;
   logic               p_rd_c, p_rs1_c, p_rs2_c;
   logic [FU_S_W-1:0]  sel_c;

   // State register: synchronous reset discards every row and all pending status.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < int'(NUM_FU); i++) row_q[i] <= '0;
         rs_valid_q <= '0;
         for (int j = 0; j < int'(NUM_REG); j++) rs_fu_q[j] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_FU); i++) row_q[i] <= row_d[i];
         rs_valid_q <= rs_valid_d;
         for (int j = 0; j < int'(NUM_REG); j++) rs_fu_q[j] <= rs_fu_d[j];
      end
   end

   // Lookup, dispatch/issue selection and next-state update.
   always_comb begin
      for (int i = 0; i < int'(NUM_FU); i++) row_d[i] = row_q[i];
      rs_valid_d  = rs_valid_q;
      for (int j = 0; j < int'(NUM_REG); j++) rs_fu_d[j] = rs_fu_q[j];
      dis_ready   = 1'b0;
      hazard      = 1'b0;
      iss_valid   = 1'b0;
      iss_fu      = '0;
      iss_rd      = '0;
      iss_rs1     = '0;
      iss_rs2     = '0;
      sel_c       = '0;
      fu_busy     = '0;

      // A writeback counts only when it targets an ISSUED row; anything else is ignored.
      wb_hit_c    = wb_valid && (32'(wb_fu) < NUM_FU) && (row_q[wb_fu].state == ISSUED);
      dis_fu_ok_c = 32'(dis_fu) < NUM_FU;

      // Pending lookups with writeback bypass; x0 is never valid in the table.
      p_rd_c  = rs_valid_q[dis_rd]  && !(wb_hit_c && (rs_fu_q[dis_rd]  == wb_fu));
      p_rs1_c = rs_valid_q[dis_rs1] && !(wb_hit_c && (rs_fu_q[dis_rs1] == wb_fu));
      p_rs2_c = rs_valid_q[dis_rs2] && !(wb_hit_c && (rs_fu_q[dis_rs2] == wb_fu));

      // Row availability uses pre-edge state, so a row freed this cycle is not reused yet.
      dis_ready = dis_fu_ok_c && (row_q[dis_fu].state == FREE) && !p_rd_c;
      hazard    = dis_valid && !dis_ready;

      // Lowest-index issuable row wins.
      for (int i = int'(NUM_FU) - 1; i >= 0; i--) begin
         if (row_q[i].state == WAIT && !row_q[i].p1 && !row_q[i].p2) begin
            iss_valid = 1'b1;
            sel_c     = FU_S_W'(i);
         end
      end
      if (iss_valid) begin
         iss_fu  = sel_c;
         iss_rd  = row_q[sel_c].r;
         iss_rs1 = row_q[sel_c].r1;
         iss_rs2 = row_q[sel_c].r2;
      end

      for (int i = 0; i < int'(NUM_FU); i++) fu_busy[i] = (row_q[i].state != FREE);

      // Writeback: free the row, retire its register, wake dependents.
      if (wb_hit_c) begin
         row_d[wb_fu].state = FREE;
         if (rs_valid_q[row_q[wb_fu].r] && (rs_fu_q[row_q[wb_fu].r] == wb_fu))
            rs_valid_d[row_q[wb_fu].r] = 1'b0;
         for (int i = 0; i < int'(NUM_FU); i++) begin
            if (row_q[i].t1 == wb_fu) row_d[i].p1 = 1'b0;
            if (row_q[i].t2 == wb_fu) row_d[i].p2 = 1'b0;
         end
      end

      if (iss_valid && iss_ready) row_d[sel_c].state = ISSUED;

      // Dispatch applied last so its register-status write overrides a same-cycle retire.
      if (dis_valid && dis_ready) begin
         row_d[dis_fu].state = WAIT;
         row_d[dis_fu].r     = dis_rd;
         row_d[dis_fu].r1    = dis_rs1;
         row_d[dis_fu].r2    = dis_rs2;
         row_d[dis_fu].t1    = rs_fu_q[dis_rs1];
         row_d[dis_fu].t2    = rs_fu_q[dis_rs2];
         row_d[dis_fu].p1    = p_rs1_c;
         row_d[dis_fu].p2    = p_rs2_c;
         if (dis_rd != '0) begin
            rs_valid_d[dis_rd] = 1'b1;
            rs_fu_d[dis_rd]    = dis_fu;
         end
      end
   end

endmodule

// File: tb/tb_scalar_fust.sv
// Self-checking bench for scalar_fust: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural scoreboard model.
module tb_scalar_fust;

   logic       CLK;
   logic       nRST;
   logic       dis_valid;
   logic [1:0] dis_fu;
   logic [4:0] dis_rd, dis_rs1, dis_rs2;
   logic       dis_ready, hazard;
   logic       iss_valid;
   logic [1:0] iss_fu;
   logic [4:0] iss_rd, iss_rs1, iss_rs2;
   logic       iss_ready;
   logic       wb_valid;
   logic [1:0] wb_fu;
   logic [2:0] fu_busy;

   int passed;
   int total;

   scalar_fust #(.NUM_FU(3), .FU_S_W(2), .REG_W(5)) dut (
      .CLK(CLK), .nRST(nRST),
      .dis_valid(dis_valid), .dis_fu(dis_fu), .dis_rd(dis_rd), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2),
      .dis_ready(dis_ready), .hazard(hazard),
      .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_fu(wb_fu), .fu_busy(fu_busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural model: instruction slot per FU (0 empty, 1 waiting, 2 in flight),
   // plus which FU will produce each register.
   int m_st [3];
   int m_r [3], m_r1 [3], m_r2 [3], m_t1 [3], m_t2 [3];
   bit m_p1 [3], m_p2 [3];
   bit m_rv [32];
   int m_rf [32];

   function automatic bit m_wbhit();
      return wb_valid && (int'(wb_fu) < 3) && (m_st[wb_fu] == 2);
   endfunction

   function automatic bit m_pend(int r);
      return (r != 0) && m_rv[r] && !(m_wbhit() && m_rf[r] == int'(wb_fu));
   endfunction

   function automatic bit m_dready();
      return (int'(dis_fu) < 3) && (m_st[dis_fu] == 0) && !m_pend(int'(dis_rd));
   endfunction

   function automatic int m_sel();
      for (int i = 0; i < 3; i++)
         if (m_st[i] == 1 && !m_p1[i] && !m_p2[i]) return i;
      return -1;
   endfunction

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic tick();
      bit rst  = !nRST;
      bit wbh  = m_wbhit();
      int wf   = int'(wb_fu);
      int sel  = iss_ready ? m_sel() : -1;
      bit dacc = dis_valid && m_dready();
      int df = int'(dis_fu), rd = int'(dis_rd), r1 = int'(dis_rs1), r2 = int'(dis_rs2);
      bit p1 = m_pend(r1), p2 = m_pend(r2);
      int t1 = m_rf[r1], t2 = m_rf[r2];
      @(posedge CLK);
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_r[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
            m_t1[i] = 0; m_t2[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
         end
         for (int j = 0; j < 32; j++) begin m_rv[j] = 0; m_rf[j] = 0; end
      end else begin
         if (wbh) begin
            m_st[wf] = 0;
            if (m_rv[m_r[wf]] && m_rf[m_r[wf]] == wf) m_rv[m_r[wf]] = 0;
            for (int i = 0; i < 3; i++) begin
               if (m_t1[i] == wf) m_p1[i] = 0;
               if (m_t2[i] == wf) m_p2[i] = 0;
            end
         end
         if (sel >= 0) m_st[sel] = 2;
         if (dacc) begin
            m_st[df] = 1; m_r[df] = rd; m_r1[df] = r1; m_r2[df] = r2;
            m_t1[df] = t1; m_t2[df] = t2; m_p1[df] = p1; m_p2[df] = p2;
            if (rd != 0) begin m_rv[rd] = 1; m_rf[rd] = df; end
         end
      end
      #1;
   endtask

   task automatic idle();
      dis_valid = 0; dis_fu = 0; dis_rd = 0; dis_rs1 = 0; dis_rs2 = 0;
      iss_ready = 0; wb_valid = 0; wb_fu = 0;
   endtask

   task automatic do_reset();
      idle(); nRST = 0; tick(); tick(); nRST = 1;
   endtask

   task automatic dispatch(input int fu, input int rd, input int r1, input int r2);
      dis_valid = 1; dis_fu = 2'(fu); dis_rd = 5'(rd); dis_rs1 = 5'(r1); dis_rs2 = 5'(r2);
   endtask

   task automatic test_reset();
      idle(); nRST = 0; dispatch(0, 5, 1, 2);
      tick(); tick(); #1;
      total++; if (fu_busy !== 3'b000) $display("FAIL reset_busy got %b exp 000", fu_busy); else passed++;
      total++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid got %b exp 0", iss_valid); else passed++;
      total++; if (hazard !== 1'b0) $display("FAIL reset_hazard got %b exp 0", hazard); else passed++;
      total++; if (dis_ready !== 1'b1) $display("FAIL reset_dis_ready got %b exp 1", dis_ready); else passed++;
      total++; if (iss_rd !== 5'd0) $display("FAIL reset_iss_rd got %0d exp 0", iss_rd); else passed++;
      nRST = 1; tick();
      dis_valid = 0; #1;
      total++; if (iss_valid !== 1'b1) $display("FAIL first_iss_valid got %b exp 1", iss_valid); else passed++;
      total++; if (iss_fu !== 2'd0) $display("FAIL first_iss_fu got %0d exp 0", iss_fu); else passed++;
      total++; if (iss_rd !== 5'd5) $display("FAIL first_iss_rd got %0d exp 5", iss_rd); else passed++;
      total++; if ({iss_rs1, iss_rs2} !== {5'd1, 5'd2}) $display("FAIL first_iss_rs got %0d,%0d exp 1,2", iss_rs1, iss_rs2); else passed++;
      total++; if (fu_busy !== 3'b001) $display("FAIL first_busy got %b exp 001", fu_busy); else passed++;
   endtask

   task automatic test_raw();
      do_reset();
      dispatch(0, 5, 1, 2); tick();
      iss_ready = 1; dispatch(1, 6, 5, 0); #1;
      total++; if (dis_ready !== 1'b1) $display("FAIL raw_dis_ready got %b exp 1", dis_ready); else passed++;
      tick(); dis_valid = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (iss_valid !== 1'b0) $display("FAIL raw_wait_c%0d got %b exp 0", c, iss_valid); else passed++;
         tick();
      end
      wb_valid = 1; wb_fu = 0; #1;
      total++; if (iss_valid !== 1'b0) $display("FAIL raw_wb_cycle got %b exp 0", iss_valid); else passed++;
      tick(); wb_valid = 0; iss_ready = 0; #1;
      total++; if (iss_valid !== 1'b1 || iss_fu !== 2'd1) $display("FAIL raw_wake got v=%b fu=%0d exp v=1 fu=1", iss_valid, iss_fu); else passed++;
      total++; if (iss_rs1 !== 5'd5) $display("FAIL raw_wake_rs1 got %0d exp 5", iss_rs1); else passed++;
      total++; if (fu_busy !== 3'b010) $display("FAIL raw_busy got %b exp 010", fu_busy); else passed++;
   endtask

   task automatic test_structural();
      do_reset();
      dispatch(0, 5, 1, 2); tick();
      dispatch(0, 7, 1, 2); #1;
      total++; if ({dis_ready, hazard} !== 2'b01) $display("FAIL struct_busy got rdy=%b hz=%b exp 0,1", dis_ready, hazard); else passed++;
      dispatch(2, 5, 3, 4); #1;
      total++; if ({dis_ready, hazard} !== 2'b01) $display("FAIL struct_waw got rdy=%b hz=%b exp 0,1", dis_ready, hazard); else passed++;
      dispatch(2, 0, 3, 4); #1;
      total++; if ({dis_ready, hazard} !== 2'b10) $display("FAIL struct_x0 got rdy=%b hz=%b exp 1,0", dis_ready, hazard); else passed++;
      dis_valid = 0; dis_fu = 0; #1;
      total++; if ({dis_ready, hazard} !== 2'b00) $display("FAIL struct_novalid got rdy=%b hz=%b exp 0,0", dis_ready, hazard); else passed++;
      tick();
   endtask

   task automatic test_bypass();
      do_reset();
      dispatch(0, 5, 1, 2); tick();
      dis_valid = 0; iss_ready = 1; tick();
      iss_ready = 0; dispatch(2, 9, 5, 0); wb_valid = 1; wb_fu = 0; #1;
      total++; if (dis_ready !== 1'b1) $display("FAIL bypass_dis_ready got %b exp 1", dis_ready); else passed++;
      tick(); idle(); #1;
      total++; if (iss_valid !== 1'b1 || iss_fu !== 2'd2) $display("FAIL bypass_issue got v=%b fu=%0d exp v=1 fu=2", iss_valid, iss_fu); else passed++;
      total++; if (fu_busy !== 3'b100) $display("FAIL bypass_busy got %b exp 100", fu_busy); else passed++;
   endtask

   task automatic test_priority();
      do_reset();
      dispatch(0, 1, 3, 4); tick();
      dispatch(2, 2, 3, 4); tick();
      dis_valid = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (iss_valid !== 1'b1 || iss_fu !== 2'd0 || iss_rd !== 5'd1) $display("FAIL prio_stall_c%0d got v=%b fu=%0d rd=%0d exp 1,0,1", c, iss_valid, iss_fu, iss_rd); else passed++;
         tick();
      end
      iss_ready = 1; #1;
      total++; if (iss_fu !== 2'd0) $display("FAIL prio_first got %0d exp 0", iss_fu); else passed++;
      tick(); #1;
      total++; if (iss_valid !== 1'b1 || iss_fu !== 2'd2 || iss_rd !== 5'd2) $display("FAIL prio_second got v=%b fu=%0d rd=%0d exp 1,2,2", iss_valid, iss_fu, iss_rd); else passed++;
      tick(); #1;
      total++; if (iss_valid !== 1'b0 || iss_fu !== 2'd0) $display("FAIL prio_drained got v=%b fu=%0d exp 0,0", iss_valid, iss_fu); else passed++;
      total++; if (fu_busy !== 3'b101) $display("FAIL prio_busy got %b exp 101", fu_busy); else passed++;
      idle();
   endtask

   task automatic test_spurious();
      do_reset();
      dispatch(0, 5, 1, 2); tick();
      dispatch(1, 6, 5, 0); tick();
      dis_valid = 0; wb_valid = 1; wb_fu = 1; tick();
      wb_fu = 0; tick();
      wb_valid = 0; #1;
      total++; if (fu_busy !== 3'b011) $display("FAIL spur_busy got %b exp 011", fu_busy); else passed++;
      total++; if (iss_valid !== 1'b1 || iss_fu !== 2'd0) $display("FAIL spur_alu got v=%b fu=%0d exp 1,0", iss_valid, iss_fu); else passed++;
      iss_ready = 1; tick(); #1;
      total++; if (iss_valid !== 1'b0) $display("FAIL spur_ldst_pending got %b exp 0", iss_valid); else passed++;
      idle();
   endtask

   task automatic test_random();
      int ef, sel;
      logic [2:0] eb;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         nRST      = ($urandom_range(0, 149) != 0);
         dis_valid = ($urandom_range(0, 9) < 7);
         dis_fu    = 2'($urandom_range(0, 2));
         dis_rd    = 5'($urandom_range(0, 7));
         dis_rs1   = 5'($urandom_range(0, 7));
         dis_rs2   = 5'($urandom_range(0, 7));
         iss_ready = ($urandom_range(0, 9) < 6);
         wb_valid  = ($urandom_range(0, 9) < 5);
         wb_fu     = 2'($urandom_range(0, 2));
         #1;
         if (nRST) begin
            sel = m_sel();
            ef  = (sel < 0) ? 0 : sel;
            eb  = {m_st[2] != 0, m_st[1] != 0, m_st[0] != 0};
            total++; if (dis_ready !== m_dready()) $display("FAIL rnd_dis_ready c%0d got %b exp %b", c, dis_ready, m_dready()); else passed++;
            total++; if (hazard !== (dis_valid && !m_dready())) $display("FAIL rnd_hazard c%0d got %b exp %b", c, hazard, dis_valid && !m_dready()); else passed++;
            total++; if (iss_valid !== (sel >= 0)) $display("FAIL rnd_iss_valid c%0d got %b exp %b", c, iss_valid, sel >= 0); else passed++;
            total++; if (iss_fu !== 2'(ef)) $display("FAIL rnd_iss_fu c%0d got %0d exp %0d", c, iss_fu, ef); else passed++;
            total++; if (iss_rd !== ((sel < 0) ? 5'd0 : 5'(m_r[ef]))) $display("FAIL rnd_iss_rd c%0d got %0d exp %0d", c, iss_rd, (sel < 0) ? 0 : m_r[ef]); else passed++;
            total++; if ({iss_rs1, iss_rs2} !== ((sel < 0) ? 10'd0 : {5'(m_r1[ef]), 5'(m_r2[ef])})) $display("FAIL rnd_iss_rs c%0d got %0d,%0d", c, iss_rs1, iss_rs2); else passed++;
            total++; if (fu_busy !== eb) $display("FAIL rnd_busy c%0d got %b exp %b", c, fu_busy, eb); else passed++;
         end
         tick();
      end
      nRST = 1; idle();
   endtask

   initial begin
      passed = 0; total = 0;
      idle(); nRST = 0;
      test_reset();
      test_raw();
      test_structural();
      test_bypass();
      test_priority();
      test_spurious();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/scalar_fust.md
# scalar_fust

Scalar functional-unit status table (scoreboard) between dispatch and the scalar functional units (ALU, LD_ST, BRANCH). It accepts one decoded scalar instruction per cycle from dispatch, records it in the row of its target FU, tracks RAW dependences through a per-register result-status table, and issues one operand-ready instruction per cycle. FU writeback frees the row and wakes up dependents. It raises the dispatch hazard when an instruction cannot be accepted.

## Interface
- NUM_FU, 3, number of scalar FU rows; row index = FU id (ALU=0, LD_ST=1, BRANCH=2); must be ≤ 2^FU_S_W
- FU_S_W, 2, FU id width
- REG_W, 5, register index width (32 registers)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  synchronous, active-low reset
- dis_valid  in  1  dispatch presents an instruction
- dis_fu  in  FU_S_W  target FU row
- dis_rd / dis_rs1 / dis_rs2  in  REG_W  destination and source registers
- dis_ready  out  1  row dis_fu FREE and dis_rd not pending (after writeback bypass); combinational
- hazard  out  1  dis_valid & ~dis_ready (drives dispatch_t.hazard)
- iss_valid  out  1  an issuable row exists
- iss_fu  out  FU_S_W  selected row
- iss_rd / iss_rs1 / iss_rs2  out  REG_W  fields of selected row
- iss_ready  in  1  FU accepts issue
- wb_valid  in  1  FU completes
- wb_fu  in  FU_S_W  completing FU id
- fu_busy  out  NUM_FU  per-row busy (state ≠ FREE)

## Operation
- Row fields: state {FREE, WAIT, ISSUED}, r, r1, r2, t1, t2 (producer FU ids), p1, p2 (pending flags).
- Register status: per register, valid bit + producer FU id. Register 0 never marked pending; reads of x0 never pending.
- Source lookup with bypass: rsN pending iff regstat[rsN].valid and not (wb_valid & regstat[rsN].fu == wb_fu). Same rule for dis_rd WAW check.
- Dispatch accept (dis_valid & dis_ready): row dis_fu ← WAIT, r/r1/r2 loaded, tN ← producer id, pN ← pending per lookup; regstat[dis_rd] ← {1, dis_fu} if dis_rd ≠ 0.
- Issuable row: state WAIT, p1=0, p2=0. Select lowest index. iss_* reflect that row combinationally; zeros when iss_valid=0.
- Issue fire (iss_valid & iss_ready): selected row → ISSUED.
- Writeback: if row wb_fu is ISSUED → FREE; clear regstat[row.r] if its producer == wb_fu; in every row, clear pN where tN == wb_fu. wb_valid on a non-ISSUED row is ignored entirely (no state change).
- Simultaneous dispatch and writeback to same register: dispatch's regstat write wins.
- Row freed by writeback is not reusable in the same cycle (dis_ready uses pre-edge state).
- Dispatch, issue and writeback may all fire in one cycle; they touch disjoint state except as above.

## Timing
- Reset (nRST=0 at edge): all rows FREE, fields 0, regstat cleared. Outputs after reset: dis_ready=1 for any dis_rd, hazard=0, iss_valid=0, iss_* =0, fu_busy=0.
- Dispatch accepted cycle N with no pending sources → iss_valid cycle N+1.
- Writeback cycle M of last producer → dependent issuable cycle M+1.
- Dispatch in cycle M whose source producer writes back in cycle M → sources recorded not pending; issuable M+1.
- Writeback cycle M → fu_busy bit clear and row dispatchable cycle M+1.
- iss_valid held with stable fields while iss_ready=0.
- Reset mid-operation discards all rows and pending state.

## Test plan
- Reset: hold nRST=0 two cycles with dis_valid=1 → fu_busy=000, iss_valid=0, hazard=0; after release, dispatch ALU rd=5 rs1=1 rs2=2 cycle 0 → iss_valid=1, iss_fu=0, iss_rd=5 cycle 1.
- RAW: ALU x5←x1,x2 issued; dispatch LD_ST rs1=5 → no issue until wb_fu=0 cycle M; LD_ST issues M+1.
- Structural/WAW: ALU busy, dispatch ALU → hazard=1, dis_ready=0; x5 pending, dispatch BRANCH rd=5 → hazard=1; x0 as rd never blocks.
- Writeback bypass: dispatch BRANCH rs1=5 same cycle as wb_fu=0 (producer of x5) → p1=0, issue next cycle.
- Issue priority/stall: ALU and BRANCH both ready, iss_ready=0 for 3 cycles → iss_fu=0 stable; iss_ready=1 → ALU then BRANCH in consecutive cycles.
- Spurious wb: wb_valid with wb_fu=1 while LD_ST WAIT → no change, row remains WAIT.
